// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: arbiter states, master
// identifiers, watchdog width and the round-robin pick helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  localparam int unsigned WDOG_WIDTH = 16;

  // Winner for an idle bus; on a tie the master that did not own the bus last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    logic pick;
    pick = ARB_M0;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = ARB_M1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus-hold watchdog: counts strobed cycles without a slave ack while the bus is
// granted and flags a timeout when the count reaches TIMEOUT.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic granted_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam logic [WDOG_WIDTH-1:0] LIMIT = WDOG_WIDTH'(TIMEOUT);

  logic [WDOG_WIDTH-1:0] cnt_q, cnt_d;

  // Idle cycles clear the count, so every new grant starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!granted_i || ack_i) begin
      cnt_d = '0;
    end else if (stb_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = granted_i && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter in front of a single slave.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_adr,
  input  logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_adr,
  input  logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_adr,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT must be within 1..65535");
  end

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       wdog_err;

  logic [1:0] gnt_vec;
  logic [1:0] cyc_vec;
  logic [1:0] ack_vec;
  logic [1:0] err_vec;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .granted_i (state_q != ARB_IDLE),
    .stb_i     (s_stb),
    .ack_i     (s_ack),
    .timeout_o (wdog_err)
  );
`else
  assign wdog_err = 1'b0;
`endif

  // An owner always passes through IDLE before the other master is granted,
  // which gives the slave a cycle to clear its ack.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_cyc || m1_cyc) begin
          state_d = (rr_pick(m0_cyc, m1_cyc, last_q) == ARB_M0) ? ARB_GNT0 : ARB_GNT1;
        end
      end
      ARB_GNT0: begin
        if (!m0_cyc || wdog_err) begin
          state_d = ARB_IDLE;
          last_d  = ARB_M0;
        end
      end
      ARB_GNT1: begin
        if (!m1_cyc || wdog_err) begin
          state_d = ARB_IDLE;
          last_d  = ARB_M1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    case (state_q)
      ARB_GNT0: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_stb;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_dat_o = m0_dat_o;
      end
      ARB_GNT1: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_stb;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_dat_o = m1_dat_o;
      end
      default: begin
      end
    endcase
  end

  assign gnt_vec = {state_q == ARB_GNT1, state_q == ARB_GNT0};
  assign cyc_vec = {m1_cyc, m0_cyc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign ack_vec[gi] = s_ack & gnt_vec[gi] & cyc_vec[gi];
    assign err_vec[gi] = wdog_err & gnt_vec[gi];
  end

  assign m0_ack   = ack_vec[0];
  assign m1_ack   = ack_vec[1];
  assign m0_err   = err_vec[0];
  assign m1_err   = err_vec[1];
  assign m0_dat_i = s_dat_i;
  assign m1_dat_i = s_dat_i;

endmodule
